seqmon_engine: RTL and testbench

Synthesizable, parametrised checker for the bus-protocol sequence "C ##1 B[*BMIN:BMAX] ##1 A |=> J[*JLEN] ##1 K", with X as an abort.
- Runs NCH independent channels in parallel.
- Reports every overlapping attempt and keeps aggregate pass, fail and abort counters.
- Sits beside the stimulus or DUT in training and emulation builds, where simulator assertions are unavailable.

---
 rtl/seqmon_pkg.sv | 37 +++
 rtl/seqmon_chan.sv | 99 +++++++++
 rtl/seqmon_engine.sv | 185 ++++++++++++++++++
 tb/tb_seqmon_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seqmon_pkg.sv
// rtl/seqmon_pkg.sv - shared types, width helpers and parameter checks for seqmon_engine
// Purpose: fail_kind_e, derived-width functions and the parameter legality test.
// Ports: none (package).
package seqmon_pkg;

  typedef enum logic [1:0] {
    FK_NONE = 2'd0,
    FK_J    = 2'd1,
    FK_K    = 2'd2
  } fail_kind_e;

  // Width of a per-sample popcount summed over all channels.
  function automatic int calc_pcw(input int nch, input int jlen);
    return $clog2(nch * (jlen + 1) + 1);
  endfunction

  // Width of one channel's per-sample popcount (up to JLEN+1 attempts).
  function automatic int calc_cpw(input int jlen);
    return $clog2(jlen + 2);
  endfunction

  // Width of the saturating B run counter (0..BMAX).
  function automatic int calc_brw(input int bmax);
    return $clog2(bmax + 1);
  endfunction

  // Width of a channel index, never below one bit.
  function automatic int calc_chw(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic bit params_ok(input int nch, input int bmin, input int bmax,
                                   input int jlen, input int cntw);
    return (nch >= 1) && (bmin >= 1) && (bmax >= bmin) && (jlen >= 1) && (cntw >= 1);
  endfunction

endpackage

// File: rtl/seqmon_chan.sv
// rtl/seqmon_chan.sv - one channel of the C ##1 B[*BMIN:BMAX] ##1 A |=> J[*JLEN] ##1 K checker
// Purpose: C history, B run counter, antecedent match, pending-attempt shift register,
//          per-sample pass/fail/abort popcounts and (with SEQMON_FAIL_LOG_EN) the fail kind.
// Ports: clk, rst_n (async active-low), en (freeze when 0), a/b/c/j/k/x protocol inputs;
//        pass_hit (one attempt passed this sample), fail_n / abort_n (attempt popcounts),
//        fail_kind (SEQMON_FAIL_LOG_EN only). All outputs are combinational from this sample.
module seqmon_chan import seqmon_pkg::*; #(
  parameter int BMIN = 1,
  parameter int BMAX = 3,
  parameter int JLEN = 4,
  parameter int CPW  = calc_cpw(JLEN)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           a,
  input  logic           b,
  input  logic           c,
  input  logic           j,
  input  logic           k,
  input  logic           x,
  output logic           pass_hit,
  output logic [CPW-1:0] fail_n,
  output logic [CPW-1:0] abort_n
`ifdef SEQMON_FAIL_LOG_EN
  ,
  output fail_kind_e     fail_kind
`endif
);

  localparam int BRW = calc_brw(BMAX);

  // c_hist_q[m] holds C from m+1 samples ago; b_run_q is b_run of the previous sample.
  logic [BMAX:0]   c_hist_q, c_hist_d;
  logic [BRW-1:0]  b_run_q, b_run_d;
  logic [JLEN+1:1] pend_q, pend_d;
  logic            match;
  logic [JLEN:1]   j_fail;
  logic            k_fail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_hist_q <= '0;
      b_run_q  <= '0;
      pend_q   <= '0;
    end else begin
      c_hist_q <= c_hist_d;
      b_run_q  <= b_run_d;
      pend_q   <= pend_d;
    end
  end

  // All run lengths that fit share one consequent, so they collapse to a single match.
  always_comb begin
    match = 1'b0;
    for (int n = BMIN; n <= BMAX; n++) begin
      if ((BRW'(n) <= b_run_q) && c_hist_q[n]) match = 1'b1;
    end
    match = match & a;
  end

  always_comb begin
    j_fail   = pend_q[JLEN:1] & {JLEN{~j}};
    k_fail   = pend_q[JLEN+1] & ~k;
    c_hist_d = c_hist_q;
    b_run_d  = b_run_q;
    pend_d   = pend_q;
    pass_hit = 1'b0;
    fail_n   = '0;
    abort_n  = '0;
`ifdef SEQMON_FAIL_LOG_EN
    fail_kind = FK_NONE;
`endif
    if (en) begin
      if (x) begin
        // Abort wipes the channel; any C, match or decision at this sample is discarded.
        c_hist_d = '0;
        b_run_d  = '0;
        pend_d   = '0;
        for (int i = 1; i <= JLEN + 1; i++) abort_n = abort_n + CPW'(pend_q[i]);
      end else begin
        c_hist_d = {c_hist_q[BMAX-1:0], c};
        if (!b)                           b_run_d = '0;
        else if (b_run_q == BRW'(BMAX))   b_run_d = b_run_q;
        else                              b_run_d = b_run_q + BRW'(1);
        // Survivors of the J checks move up; the K stage always retires.
        pend_d   = {pend_q[JLEN:1] & {JLEN{j}}, match};
        pass_hit = pend_q[JLEN+1] & k;
        fail_n   = CPW'(k_fail);
        for (int i = 1; i <= JLEN; i++) fail_n = fail_n + CPW'(j_fail[i]);
`ifdef SEQMON_FAIL_LOG_EN
        if (k_fail)       fail_kind = FK_K;
        else if (|j_fail) fail_kind = FK_J;
`endif
      end
    end
  end

endmodule

// File: rtl/seqmon_engine.sv
// rtl/seqmon_engine.sv - NCH-channel sequence checker with shared saturating statistics
// Purpose: instantiates NCH seqmon_chan, registers PASS/FAIL pulses, sums popcounts into
//          saturating PASS_CNT/FAIL_CNT/ABORT_CNT. Optional macro SEQMON_FAIL_LOG_EN adds a
//          first-failure log (FLOG_VLD, FLOG_CH, FLOG_KIND, FLOG_CYC).
// Ports: CLK, RST_N (async active-low), EN (0 freezes everything), CLR_CNT (sync counter clear),
//        A/B/C/J/K/X [NCH] protocol inputs, PASS/FAIL [NCH] pulses, three CNTW-bit counters.
module seqmon_engine import seqmon_pkg::*; #(
  parameter int NCH  = 2,
  parameter int BMIN = 1,
  parameter int BMAX = 3,
  parameter int JLEN = 4,
  parameter int CNTW = 16
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       EN,
  input  logic                       CLR_CNT,
  input  logic [NCH-1:0]             A,
  input  logic [NCH-1:0]             B,
  input  logic [NCH-1:0]             C,
  input  logic [NCH-1:0]             J,
  input  logic [NCH-1:0]             K,
  input  logic [NCH-1:0]             X,
  output logic [NCH-1:0]             PASS,
  output logic [NCH-1:0]             FAIL,
  output logic [CNTW-1:0]            PASS_CNT,
  output logic [CNTW-1:0]            FAIL_CNT,
  output logic [CNTW-1:0]            ABORT_CNT
`ifdef SEQMON_FAIL_LOG_EN
  ,
  output logic                       FLOG_VLD,
  output logic [calc_chw(NCH)-1:0]   FLOG_CH,
  output fail_kind_e                 FLOG_KIND,
  output logic [CNTW-1:0]            FLOG_CYC
`endif
);

  localparam int PCW = calc_pcw(NCH, JLEN);
  localparam int CPW = calc_cpw(JLEN);
  localparam int SW  = ((CNTW > PCW) ? CNTW : PCW) + 1;

  if (!params_ok(NCH, BMIN, BMAX, JLEN, CNTW)) begin : g_bad_params
    $error("seqmon_engine: illegal parameter combination");
  end

  logic [NCH-1:0] pass_hit;
  logic [NCH-1:0] fail_now;
  logic [CPW-1:0] fail_n_w  [NCH];
  logic [CPW-1:0] abort_n_w [NCH];
  logic [PCW-1:0] pass_sum, fail_sum, abort_sum;
`ifdef SEQMON_FAIL_LOG_EN
  fail_kind_e     kind_w    [NCH];
`endif

  for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
    seqmon_chan #(.BMIN(BMIN), .BMAX(BMAX), .JLEN(JLEN), .CPW(CPW)) u_chan (
      .clk      (CLK),
      .rst_n    (RST_N),
      .en       (EN),
      .a        (A[ch]),
      .b        (B[ch]),
      .c        (C[ch]),
      .j        (J[ch]),
      .k        (K[ch]),
      .x        (X[ch]),
      .pass_hit (pass_hit[ch]),
      .fail_n   (fail_n_w[ch]),
      .abort_n  (abort_n_w[ch])
`ifdef SEQMON_FAIL_LOG_EN
      ,
      .fail_kind(kind_w[ch])
`endif
    );
  end

  always_comb begin
    pass_sum  = '0;
    fail_sum  = '0;
    abort_sum = '0;
    fail_now  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      pass_sum     = pass_sum  + PCW'(pass_hit[ch]);
      fail_sum     = fail_sum  + PCW'(fail_n_w[ch]);
      abort_sum    = abort_sum + PCW'(abort_n_w[ch]);
      fail_now[ch] = |fail_n_w[ch];
    end
  end

  function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] cnt,
                                              input logic [PCW-1:0]  inc);
    logic [SW-1:0] s;
    s = SW'(cnt) + SW'(inc);
    return (|s[SW-1:CNTW]) ? {CNTW{1'b1}} : s[CNTW-1:0];
  endfunction

  logic [NCH-1:0]  pass_q, pass_d, fail_q, fail_d;
  logic [CNTW-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d, abort_cnt_q, abort_cnt_d;

  // Channel outputs are already zero while EN=0, so sums add nothing then.
  always_comb begin
    pass_d      = pass_hit;
    fail_d      = fail_now;
    pass_cnt_d  = CLR_CNT ? '0 : sat_add(pass_cnt_q,  pass_sum);
    fail_cnt_d  = CLR_CNT ? '0 : sat_add(fail_cnt_q,  fail_sum);
    abort_cnt_d = CLR_CNT ? '0 : sat_add(abort_cnt_q, abort_sum);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pass_q      <= '0;
      fail_q      <= '0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      abort_cnt_q <= '0;
    end else begin
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign PASS      = pass_q;
  assign FAIL      = fail_q;
  assign PASS_CNT  = pass_cnt_q;
  assign FAIL_CNT  = fail_cnt_q;
  assign ABORT_CNT = abort_cnt_q;

`ifdef SEQMON_FAIL_LOG_EN
  localparam int CHW = calc_chw(NCH);

  logic [CNTW-1:0] cyc_q, cyc_d;
  logic            flog_vld_q, flog_vld_d;
  logic [CHW-1:0]  flog_ch_q, flog_ch_d;
  fail_kind_e      flog_kind_q, flog_kind_d;
  logic [CNTW-1:0] flog_cyc_q, flog_cyc_d;

  always_comb begin
    cyc_d       = EN ? cyc_q + CNTW'(1) : cyc_q;
    flog_vld_d  = flog_vld_q;
    flog_ch_d   = flog_ch_q;
    flog_kind_d = flog_kind_q;
    flog_cyc_d  = flog_cyc_q;
    if (CLR_CNT) begin
      flog_vld_d  = 1'b0;
      flog_ch_d   = '0;
      flog_kind_d = FK_NONE;
      flog_cyc_d  = '0;
    end else if (!flog_vld_q && (|fail_now)) begin
      flog_vld_d = 1'b1;
      flog_cyc_d = cyc_q;
      // Scan downward so the lowest failing channel is the one that sticks.
      for (int ch = NCH - 1; ch >= 0; ch--) begin
        if (fail_now[ch]) begin
          flog_ch_d   = CHW'(ch);
          flog_kind_d = kind_w[ch];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cyc_q       <= '0;
      flog_vld_q  <= 1'b0;
      flog_ch_q   <= '0;
      flog_kind_q <= FK_NONE;
      flog_cyc_q  <= '0;
    end else begin
      cyc_q       <= cyc_d;
      flog_vld_q  <= flog_vld_d;
      flog_ch_q   <= flog_ch_d;
      flog_kind_q <= flog_kind_d;
      flog_cyc_q  <= flog_cyc_d;
    end
  end

  assign FLOG_VLD  = flog_vld_q;
  assign FLOG_CH   = flog_ch_q;
  assign FLOG_KIND = flog_kind_q;
  assign FLOG_CYC  = flog_cyc_q;
`endif

endmodule

// File: tb/tb_seqmon_engine.sv
// tb/tb_seqmon_engine.sv - directed self-checking bench for seqmon_engine
module tb_seqmon_engine;
  import seqmon_pkg::*;

  localparam logic [5:0] SA = 6'd1, SB = 6'd2, SC = 6'd4, SJ = 6'd8, SK = 6'd16, SX = 6'd32, SN = 6'd0;

  logic        CLK = 1'b0;
  logic        RST_N, EN, CLR_CNT;
  logic [1:0]  A, B, C, J, K, X;
  logic [1:0]  PASS, FAIL, PASS_s, FAIL_s;
  logic [15:0] PASS_CNT, FAIL_CNT, ABORT_CNT;
  logic [1:0]  PASS_CNT_s, FAIL_CNT_s, ABORT_CNT_s;
`ifdef SEQMON_FAIL_LOG_EN
  logic        FLOG_VLD, FLOG_VLD_s;
  logic [0:0]  FLOG_CH, FLOG_CH_s;
  fail_kind_e  FLOG_KIND, FLOG_KIND_s;
  logic [15:0] FLOG_CYC;
  logic [1:0]  FLOG_CYC_s;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int npulse   = 0;

  logic [5:0] seq_pass [8] = '{SC, SB, SA, SJ, SJ, SJ, SJ, SK};

  always #5 CLK = ~CLK;

  seqmon_engine dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR_CNT(CLR_CNT),
    .A(A), .B(B), .C(C), .J(J), .K(K), .X(X),
    .PASS(PASS), .FAIL(FAIL),
    .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT), .ABORT_CNT(ABORT_CNT)
`ifdef SEQMON_FAIL_LOG_EN
    , .FLOG_VLD(FLOG_VLD), .FLOG_CH(FLOG_CH), .FLOG_KIND(FLOG_KIND), .FLOG_CYC(FLOG_CYC)
`endif
  );

  seqmon_engine #(.CNTW(2)) dut_s (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR_CNT(CLR_CNT),
    .A(A), .B(B), .C(C), .J(J), .K(K), .X(X),
    .PASS(PASS_s), .FAIL(FAIL_s),
    .PASS_CNT(PASS_CNT_s), .FAIL_CNT(FAIL_CNT_s), .ABORT_CNT(ABORT_CNT_s)
`ifdef SEQMON_FAIL_LOG_EN
    , .FLOG_VLD(FLOG_VLD_s), .FLOG_CH(FLOG_CH_s), .FLOG_KIND(FLOG_KIND_s), .FLOG_CYC(FLOG_CYC_s)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [5:0] s0, input logic [5:0] s1);
    A = {s1[0], s0[0]};
    B = {s1[1], s0[1]};
    C = {s1[2], s0[2]};
    J = {s1[3], s0[3]};
    K = {s1[4], s0[4]};
    X = {s1[5], s0[5]};
    @(posedge CLK);
    #1;
    npulse += $countones({PASS, FAIL});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(SN, SN);
  endtask

  task automatic run_pass0();
    for (int i = 0; i < 8; i++) step(seq_pass[i], SN);
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b1; CLR_CNT = 1'b0;
    A = '0; B = '0; C = '0; J = '0; K = '0; X = '0;
    @(posedge CLK); #1;
    chk("rst_pass", PASS, 0);
    chk("rst_fail", FAIL, 0);
    chk("rst_pcnt", PASS_CNT, 0);
    chk("rst_fcnt", FAIL_CNT, 0);
    chk("rst_acnt", ABORT_CNT, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // 1: antecedent without A
    npulse = 0;
    step(SC, SN); step(SB, SN); step(SB, SN); step(SB, SN);
    idle(6);
    chk("t1_pulses", npulse, 0);
    chk("t1_pcnt", PASS_CNT, 0);
    chk("t1_fcnt", FAIL_CNT, 0);

    // 2: single passing attempt
    npulse = 0;
    for (int i = 0; i < 7; i++) step(seq_pass[i], SN);
    chk("t2_early", npulse, 0);
    step(SK, SN);
    chk("t2_pass", PASS, 2'b01);
    chk("t2_fail", FAIL, 2'b00);
    chk("t2_pcnt", PASS_CNT, 1);
    chk("t2_fcnt", FAIL_CNT, 0);
    idle(1);
    chk("t2_width", PASS, 2'b00);
    idle(5);

    // 3: three overlapping attempts
    step(SC, SN); step(SB, SN); step(SB | SA, SN);
    step(SB | SA, SN);
    chk("t3_fail_a", FAIL, 2'b01);
    step(SA, SN);
    chk("t3_fail_b", FAIL, 2'b01);
    step(SJ, SN);
    chk("t3_fail_c", FAIL, 2'b00);
    npulse = 0;
    step(SJ, SN); step(SJ, SN); step(SJ, SN); step(SK, SN);
    chk("t3_pass", PASS, 2'b01);
    chk("t3_pulses", npulse, 1);
    chk("t3_pcnt", PASS_CNT, 2);
    chk("t3_fcnt", FAIL_CNT, 2);
    idle(6);

    // 4a: abort on X in the K slot
    npulse = 0;
    step(SC, SN); step(SB, SN); step(SB, SN); step(SA, SN);
    step(SJ, SN); step(SJ, SN); step(SJ, SN); step(SJ, SN); step(SX, SN);
    chk("t4a_pulses", npulse, 0);
    chk("t4a_acnt", ABORT_CNT, 1);
    idle(3);
    chk("t4a_quiet", npulse, 0);

    CLR_CNT = 1'b1; idle(1); CLR_CNT = 1'b0;
    chk("clr_pcnt", PASS_CNT, 0);
    chk("clr_fcnt", FAIL_CNT, 0);
    chk("clr_acnt", ABORT_CNT, 0);
`ifdef SEQMON_FAIL_LOG_EN
    chk("clr_flog_vld", FLOG_VLD, 0);
`endif

    // 4b: K missing one sample late
    npulse = 0;
    for (int i = 0; i < 7; i++) step(seq_pass[i], SN);
    step(SN, SN);
    chk("t4b_fail", FAIL, 2'b01);
    chk("t4b_fcnt", FAIL_CNT, 1);
`ifdef SEQMON_FAIL_LOG_EN
    chk("t4b_flog_vld", FLOG_VLD, 1);
    chk("t4b_flog_kind", FLOG_KIND, FK_K);
    chk("t4b_flog_ch", FLOG_CH, 0);
`endif
    step(SK, SN);
    chk("t4b_pulses", npulse, 1);
    idle(4);

    // 5: both channels in parallel
    for (int i = 0; i < 7; i++) step(seq_pass[i], seq_pass[i]);
    step(SK, SN);
    chk("t5_pass", PASS, 2'b01);
    chk("t5_fail", FAIL, 2'b10);
    chk("t5_pcnt", PASS_CNT, 1);
    chk("t5_fcnt", FAIL_CNT, 2);
    idle(5);

    // EN=0 freeze across a would-be J failure
    step(SC, SN); step(SB, SN); step(SA, SN);
    npulse = 0;
    EN = 1'b0; idle(3); EN = 1'b1;
    chk("en_frozen", npulse, 0);
    step(SJ, SN); step(SJ, SN); step(SJ, SN); step(SJ, SN); step(SK, SN);
    chk("en_pass", PASS, 2'b01);
    chk("en_pcnt", PASS_CNT, 2);
    chk("en_fcnt", FAIL_CNT, 2);
    idle(5);

    // 6: saturation with CNTW=2
    CLR_CNT = 1'b1; idle(1); CLR_CNT = 1'b0;
    for (int r = 0; r < 4; r++) begin
      run_pass0();
      idle(5);
      if (r == 2) chk("t6_sat3", PASS_CNT_s, 3);
    end
    chk("t6_sat4", PASS_CNT_s, 3);
    chk("t6_main4", PASS_CNT, 4);

    for (int i = 0; i < 7; i++) step(seq_pass[i], SN);
    CLR_CNT = 1'b1;
    step(SK, SN);
    CLR_CNT = 1'b0;
    chk("t6_clr_pass", PASS_s, 2'b01);
    chk("t6_clr_fail", FAIL_s, 2'b00);
    chk("t6_clr_pcnt_s", PASS_CNT_s, 0);
    chk("t6_clr_fcnt_s", FAIL_CNT_s, 0);
    chk("t6_clr_acnt_s", ABORT_CNT_s, 0);
    chk("t6_clr_pcnt", PASS_CNT, 0);
    idle(5);
    run_pass0();
    chk("t6_after_clr", PASS_CNT, 1);
    idle(5);

    // reset in the middle of an attempt
    step(SC, SN); step(SB, SN); step(SA, SN); step(SJ, SN); step(SJ, SN);
    RST_N = 1'b0;
    #1;
    chk("t6_rst_pcnt", PASS_CNT, 0);
    chk("t6_rst_pass", PASS, 2'b00);
    idle(2);
    RST_N = 1'b1;
    npulse = 0;
    step(SJ, SN); step(SJ, SN); step(SK, SN);
    idle(3);
    chk("t6_rst_quiet", npulse, 0);
    chk("t6_rst_pcnt2", PASS_CNT, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
